yarvi_wb: RTL and testbench
===========================

Name: yarvi_wb

Overview:
- Writeback/commit stage directly downstream of the memory stage.
- Consumes the per-cycle retirement record (valid, pc, insn, priv, rd, value) and maintains the architectural retire counters (cycle, instret).
- Buffers retired records in a small FIFO and drains them over a valid/ready trace port to an external sink (tracer, disassembler, co-sim checker).
- Never stalls the pipeline: records that arrive while the FIFO is full are dropped and counted.

Parameters:
LOG2_DEPTH, 3, trace FIFO depth = 2**LOG2_DEPTH entries (legal 1..6)
DROP_W, 16, width of saturating drop counter

Ports:
clock  in  1  core clock, all state on posedge
reset  in  1  asynchronous, active-high reset
me_valid  in  1  retirement record valid this cycle
me_pc  in  `VMSB+1  pc of retiring insn
me_insn  in  32  retiring instruction word
me_priv  in  2  privilege level at retirement
me_wb_rd  in  5  destination register (0 = none)
me_wb_val  in  `XMSB+1  writeback value
tr_valid  out  1  trace head record valid
tr_ready  in  1  sink accepts head record
tr_pc  out  `VMSB+1  head pc
tr_insn  out  32  head insn
tr_priv  out  2  head priv
tr_rd  out  5  head rd
tr_val  out  `XMSB+1  head value; forced 0 when tr_rd==0
ovf_clr  in  1  clear overflow flag and drop count
ovf  out  1  sticky: at least one record dropped
drop_count  out  DROP_W  saturating count of dropped records
cycle  out  64  cycles since reset
instret  out  64  records retired since reset (incl. dropped)

Behaviour:
- Reset (async assert, sync-safe deassert): read/write pointers, occupancy, ovf, drop_count, cycle, instret all 0; tr_valid=0. FIFO data not reset; tr_pc/insn/priv/rd/val are don't-care while tr_valid=0. Queued records are discarded by a mid-operation reset.
- cycle: +1 on every posedge after reset; wraps at 2**64.
- instret: +1 on every posedge with me_valid=1, whether or not the record is queued; wraps at 2**64.
- Pop: handshake occurs when tr_valid && tr_ready at posedge; head advances. tr_* hold stable while tr_valid=1 && tr_ready=0.
- Push: at posedge with me_valid=1. Accepted if occupancy < depth, or occupancy == depth and a pop happens the same edge (simultaneous push/pop at full is legal; occupancy unchanged). Simultaneous push/pop when empty is impossible (tr_valid=0); record is written and tr_valid=1 next cycle.
- Latency: record sampled at edge N is visible on tr_* with tr_valid=1 from edge N (after N) when FIFO was empty; i.e. one cycle after me_valid.
- Drop: me_valid=1, full, no pop -> record discarded, ovf<=1, drop_count<=drop_count+1 saturating at 2**DROP_W-1.
- ovf_clr: at posedge clears ovf and drop_count. If a drop happens on the same edge, the drop wins: ovf=1, drop_count=1.
- tr_val is forced to 0 when stored rd==0 (x0 writes are not architecturally visible).
- Pointers are LOG2_DEPTH bits, wrap modulo depth; occupancy is LOG2_DEPTH+1 bits; full = occupancy==depth.

Optional Feature:
YARVI_WB_RETIRE_COUNT_EN
- Defined: cycle and instret counters built as described.
- Not defined: no counter registers; cycle and instret tied to 0; FIFO/trace behaviour unchanged.

Test Plan:
- Reset then 10 idle cycles -> tr_valid=0, ovf=0, drop_count=0, cycle=10, instret=0.
- Single record pc=0x80000000 insn=0x00a00093 rd=1 val=10, tr_ready=1 -> next cycle tr_valid=1 with those values; following cycle tr_valid=0; instret=1.
- Record with rd=0 val=0xdeadbeef -> tr_rd=0, tr_val=0.
- LOG2_DEPTH=3, tr_ready=0, 10 consecutive me_valid -> 8 queued, ovf=1, drop_count=2, instret=10; then tr_ready=1 drains the first 8 records in order, tr_valid falls after 8 pops.
- Full FIFO, me_valid=1 and tr_ready=1 same edge -> no drop, occupancy stays 8, new record appears last; assert ovf_clr coincident with a drop -> ovf=1, drop_count=1.
- Assert reset asynchronously mid-drain with 5 queued -> tr_valid=0 immediately, counters 0; build without YARVI_WB_RETIRE_COUNT_EN -> cycle=instret=0 throughout.

Source files
------------

// File: rtl/yarvi_wb.sv
// yarvi_wb: writeback/commit stage.
// Counts retirements, queues retired records in a small FIFO and presents
// them on a trace port. The pipeline is never stalled; a record that arrives
// while the FIFO is full and not draining is dropped and counted.
// Optional feature macro: YARVI_WB_RETIRE_COUNT_EN (builds the cycle/instret
// counters; without it both outputs are tied to 0).
//
// Trace handshake: tr_valid is high whenever the FIFO holds a record, and the
// head record moves on only at a posedge where tr_valid && tr_ready. While
// tr_valid=1 && tr_ready=0 the tr_* fields stay stable. tr_valid never
// depends on tr_ready.

`ifndef VMSB
`define VMSB 31
`endif
`ifndef XMSB
`define XMSB 31
`endif

module yarvi_wb #(
  parameter int LOG2_DEPTH = 3,
  parameter int DROP_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                me_valid,
  input  logic [`VMSB:0]      me_pc,
  input  logic [31:0]         me_insn,
  input  logic [1:0]          me_priv,
  input  logic [4:0]          me_wb_rd,
  input  logic [`XMSB:0]      me_wb_val,
  output logic                tr_valid,
  input  logic                tr_ready,
  output logic [`VMSB:0]      tr_pc,
  output logic [31:0]         tr_insn,
  output logic [1:0]          tr_priv,
  output logic [4:0]          tr_rd,
  output logic [`XMSB:0]      tr_val,
  input  logic                ovf_clr,
  output logic                ovf,
  output logic [DROP_W-1:0]   drop_count,
  output logic [63:0]         cycle,
  output logic [63:0]         instret
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // FIFO storage (not reset; contents are only meaningful under r_count)
  logic [`VMSB:0] r_pc_mem   [DEPTH];
  logic [31:0]    r_insn_mem [DEPTH];
  logic [1:0]     r_priv_mem [DEPTH];
  logic [4:0]     r_rd_mem   [DEPTH];
  logic [`XMSB:0] r_val_mem  [DEPTH];

  logic [LOG2_DEPTH-1:0] r_wptr;
  logic [LOG2_DEPTH-1:0] r_rptr;
  logic [LOG2_DEPTH:0]   r_count;
  logic                  r_ovf;
  logic [DROP_W-1:0]     r_drop_count;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees a slot on the same edge, so a full FIFO that is draining
  // still accepts the incoming record.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = tr_valid && tr_ready;
  assign w_push = me_valid && (!w_full || w_pop);
  assign w_drop = me_valid && w_full && !w_pop;

  // Write the incoming record into the tail slot
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= me_pc;
      r_insn_mem[r_wptr] <= me_insn;
      r_priv_mem[r_wptr] <= me_priv;
      r_rd_mem[r_wptr]   <= me_wb_rd;
      r_val_mem[r_wptr]  <= me_wb_val;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop on the same
  // edge as a clear wins and restarts the count at 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf        <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (ovf_clr)
        r_drop_count <= DROP_W'(1);
      else if (r_drop_count != DROP_MAX)
        r_drop_count <= r_drop_count + 1'b1;
    end else if (ovf_clr) begin
      r_ovf        <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign ovf        = r_ovf;
  assign drop_count = r_drop_count;

  assign tr_valid = (r_count != '0);
  assign tr_pc    = r_pc_mem[r_rptr];
  assign tr_insn  = r_insn_mem[r_rptr];
  assign tr_priv  = r_priv_mem[r_rptr];
  assign tr_rd    = r_rd_mem[r_rptr];
  // x0 writes are not architecturally visible, so hide the value
  assign tr_val   = (tr_rd == 5'd0) ? '0 : r_val_mem[r_rptr];

`ifdef YARVI_WB_RETIRE_COUNT_EN
  logic [63:0] r_cycle;
  logic [63:0] r_instret;

  // Architectural retire counters; instret includes dropped records
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (me_valid) r_instret <= r_instret + 64'd1;
    end
  end

  assign cycle   = r_cycle;
  assign instret = r_instret;
`else
  assign cycle   = '0;
  assign instret = '0;
`endif

endmodule

// File: tb/tb_yarvi_wb.sv
// Testbench for yarvi_wb: directed vectors, reference occupancy model feeding
// an expected-record queue, and a negedge monitor that checks the trace port.

`ifndef VMSB
`define VMSB 31
`endif
`ifndef XMSB
`define XMSB 31
`endif

module tb_yarvi_wb;

  localparam int REC_W = (`VMSB+1) + 32 + 2 + 5 + (`XMSB+1);
  localparam int TB_DEPTH = 8;
`ifdef YARVI_WB_RETIRE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              me_valid;
  logic [`VMSB:0]    me_pc;
  logic [31:0]       me_insn;
  logic [1:0]        me_priv;
  logic [4:0]        me_wb_rd;
  logic [`XMSB:0]    me_wb_val;
  logic              tr_valid;
  logic              tr_ready;
  logic [`VMSB:0]    tr_pc;
  logic [31:0]       tr_insn;
  logic [1:0]        tr_priv;
  logic [4:0]        tr_rd;
  logic [`XMSB:0]    tr_val;
  logic              ovf_clr;
  logic              ovf;
  logic [15:0]       drop_count;
  logic [63:0]       cycle;
  logic [63:0]       instret;

  logic [REC_W-1:0]  exp_q[$];
  int                tb_occ;
  int                n_tests;
  int                n_fail;

  yarvi_wb #(.LOG2_DEPTH(3), .DROP_W(16)) dut (
    .clock(clock), .reset(reset),
    .me_valid(me_valid), .me_pc(me_pc), .me_insn(me_insn), .me_priv(me_priv),
    .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val),
    .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_pc(tr_pc), .tr_insn(tr_insn), .tr_priv(tr_priv), .tr_rd(tr_rd),
    .tr_val(tr_val),
    .ovf_clr(ovf_clr), .ovf(ovf), .drop_count(drop_count),
    .cycle(cycle), .instret(instret)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] insn,
                      input logic [1:0] priv, input logic [4:0] rd,
                      input logic [31:0] val);
    me_valid  = 1'b1;
    me_pc     = pc;
    me_insn   = insn;
    me_priv   = priv;
    me_wb_rd  = rd;
    me_wb_val = val;
    tick();
  endtask

  // Reference model: decides at each edge whether the offered record is
  // queued (room, or a pop frees a slot) and pushes its expected trace image
  always @(posedge clock) begin
    if (reset) begin
      tb_occ = 0;
    end else begin
      bit pop;
      pop = (tb_occ > 0) && tr_ready;
      if (me_valid && (tb_occ < TB_DEPTH || pop)) begin
        exp_q.push_back({me_pc, me_insn, me_priv, me_wb_rd,
                         (me_wb_rd == 5'd0) ? {(`XMSB+1){1'b0}} : me_wb_val});
        if (!pop) tb_occ++;
      end else if (pop) begin
        tb_occ--;
      end
    end
  end

  // Monitor: checks tr_valid against the scoreboard and compares the head
  // record whenever a handshake is about to happen on the next edge
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("tr_valid", 64'(tr_valid), 64'(exp_q.size() != 0));
      if (tr_valid && tr_ready && exp_q.size() != 0) begin
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        got = {tr_pc, tr_insn, tr_priv, tr_rd, tr_val};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL trace_rec: got %h expected %h", got, exp);
        end
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    tb_occ    = 0;
    reset     = 1'b1;
    me_valid  = 1'b0;
    me_pc     = '0;
    me_insn   = '0;
    me_priv   = '0;
    me_wb_rd  = '0;
    me_wb_val = '0;
    tr_ready  = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // reset state after 10 idle cycles
    repeat (10) tick();
    check("rst_tr_valid", 64'(tr_valid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_cycle", cycle, CNT_EN ? 64'd10 : 64'd0);
    check("rst_instret", instret, 64'd0);

    // single record, sink ready
    tr_ready = 1'b1;
    send(32'h8000_0000, 32'h00a0_0093, 2'd3, 5'd1, 32'd10);
    me_valid = 1'b0;
    check("single_valid", 64'(tr_valid), 64'd1);
    check("single_instret", instret, CNT_EN ? 64'd1 : 64'd0);
    tick();
    check("single_gone", 64'(tr_valid), 64'd0);

    // rd = 0 hides the value
    send(32'h8000_0004, 32'h0000_0013, 2'd3, 5'd0, 32'hdead_beef);
    me_valid = 1'b0;
    check("x0_val", 64'(tr_val), 64'd0);
    tick();

    // 10 records into a stalled 8-deep FIFO: 2 drops
    tr_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      send(32'(32'h100 + 4*i), 32'(32'h1000 + i), 2'(i), 5'(i + 1), 32'(32'h5000 + i));
    me_valid = 1'b0;
    check("ovf_set", 64'(ovf), 64'd1);
    check("drop_two", 64'(drop_count), 64'd2);
    check("instret_12", instret, CNT_EN ? 64'd12 : 64'd0);
    tr_ready = 1'b1;
    repeat (8) tick();
    check("drained", 64'(tr_valid), 64'd0);
    tr_ready = 1'b0;

    // clear on its own
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", 64'(ovf), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);

    // fill, then push and pop on the same edge while full
    for (int i = 0; i < 8; i++)
      send(32'(32'h200 + 4*i), 32'(32'h2000 + i), 2'd1, 5'(i + 3), 32'(32'h6000 + i));
    tr_ready = 1'b1;
    send(32'h300, 32'h3000, 2'd2, 5'd7, 32'h7777);
    me_valid = 1'b0;
    tr_ready = 1'b0;
    check("full_pushpop_ovf", 64'(ovf), 64'd0);
    check("full_pushpop_drop", 64'(drop_count), 64'd0);

    // drop coincident with clear: the drop wins
    ovf_clr = 1'b1;
    send(32'h400, 32'h4000, 2'd0, 5'd1, 32'h1);
    ovf_clr = 1'b0;
    check("clr_drop_ovf", 64'(ovf), 64'd1);
    check("clr_drop_cnt", 64'(drop_count), 64'd1);
    send(32'h404, 32'h4004, 2'd0, 5'd1, 32'h2);
    me_valid = 1'b0;
    check("drop_again", 64'(drop_count), 64'd2);

    // drain three, leaving five, then reset asynchronously mid-cycle
    tr_ready = 1'b1;
    repeat (3) tick();
    tr_ready = 1'b0;
    check("five_left_valid", 64'(tr_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_tr_valid", 64'(tr_valid), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    check("arst_drop", 64'(drop_count), 64'd0);
    check("arst_cycle", cycle, 64'd0);
    check("arst_instret", instret, 64'd0);
    repeat (2) tick();
    reset = 1'b0;

    // recovery: one record through an empty FIFO
    tr_ready = 1'b1;
    send(32'h8000_0100, 32'h0010_0113, 2'd3, 5'd2, 32'h1234_5678);
    me_valid = 1'b0;
    check("post_rst_instret", instret, CNT_EN ? 64'd1 : 64'd0);
    repeat (2) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
